// File: rtl/trap_pkg.sv
// Shared types and constants for the trap/return sequencer: FSM states,
// interrupt cause codes and privilege mode encodings.
package trap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_COMMIT   = 2'd2,
        ST_REDIRECT = 2'd3
    } trap_state_t;

    localparam logic [4:0] IRQ_MEI = 5'd11;
    localparam logic [4:0] IRQ_MTI = 5'd7;
    localparam logic [4:0] IRQ_SEI = 5'd9;
    localparam logic [4:0] IRQ_STI = 5'd5;

    localparam logic [1:0] MODE_U = 2'b00;
    localparam logic [1:0] MODE_S = 2'b01;
    localparam logic [1:0] MODE_M = 2'b11;

endpackage

// File: rtl/trap_sequencer_if.sv
// Bundle between the trap sequencer and its neighbours: execute/decode
// requests, csr_regfile status/commit, pipeline flush handshake, front-end redirect.
interface trap_sequencer_if #(
    parameter int XLEN = 32
);
    logic            exc_valid;
    logic [5:0]      exc_cause;
    logic [XLEN-1:0] exc_pc;
    logic            mret_req;
    logic            sret_req;
    logic [XLEN-1:0] commit_pc;
    logic [1:0]      current_mode;
    logic            m_eie;
    logic            m_tie;
    logic            s_eie;
    logic            s_tie;
    logic            m_interrupt;
    logic            m_timer;
    logic            s_interrupt;
    logic            s_timer;
    logic            flush_ack;

    logic            flush_req;
    logic            exception_pending;
    logic [XLEN-1:0] m_cause;
    logic [XLEN-1:0] pc_exc;
    logic            m_ret;
    logic            s_ret;
    logic            redirect;
    logic            busy;
    logic            drain_timeout_err;

    // master is the sequencer itself; slave is the surrounding pipeline/CSR side
    modport master (
        input  exc_valid, exc_cause, exc_pc, mret_req, sret_req, commit_pc,
        input  current_mode, m_eie, m_tie, s_eie, s_tie,
        input  m_interrupt, m_timer, s_interrupt, s_timer, flush_ack,
        output flush_req, exception_pending, m_cause, pc_exc, m_ret, s_ret,
        output redirect, busy, drain_timeout_err
    );

    modport slave (
        output exc_valid, exc_cause, exc_pc, mret_req, sret_req, commit_pc,
        output current_mode, m_eie, m_tie, s_eie, s_tie,
        output m_interrupt, m_timer, s_interrupt, s_timer, flush_ack,
        input  flush_req, exception_pending, m_cause, pc_exc, m_ret, s_ret,
        input  redirect, busy, drain_timeout_err
    );

endinterface

// File: rtl/irq_priority_enc.sv
// Interrupt eligibility against current privilege mode and enables, then
// fixed-priority selection MEI > MTI > SEI > STI.
module irq_priority_enc
    import trap_pkg::*;
(
    input  logic [1:0] current_mode,
    input  logic       m_eie,
    input  logic       m_tie,
    input  logic       s_eie,
    input  logic       s_tie,
    input  logic       m_interrupt,
    input  logic       m_timer,
    input  logic       s_interrupt,
    input  logic       s_timer,
    input  logic       irq_block,
    output logic       irq_valid,
    output logic [4:0] irq_code
);

    logic mei_ok;
    logic mti_ok;
    logic sei_ok;
    logic sti_ok;

    // M-level sources are always enabled below M; S-level never taken from M
    always_comb begin
        mei_ok = m_interrupt && ((current_mode != MODE_M) || m_eie);
        mti_ok = m_timer     && ((current_mode != MODE_M) || m_tie);
        sei_ok = s_interrupt && ((current_mode == MODE_U) || ((current_mode == MODE_S) && s_eie));
        sti_ok = s_timer     && ((current_mode == MODE_U) || ((current_mode == MODE_S) && s_tie));
    end

    always_comb begin
        irq_valid = 1'b0;
        irq_code  = 5'd0;
        if (!irq_block) begin
            if (mei_ok) begin
                irq_valid = 1'b1;
                irq_code  = IRQ_MEI;
            end else if (mti_ok) begin
                irq_valid = 1'b1;
                irq_code  = IRQ_MTI;
            end else if (sei_ok) begin
                irq_valid = 1'b1;
                irq_code  = IRQ_SEI;
            end else if (sti_ok) begin
                irq_valid = 1'b1;
                irq_code  = IRQ_STI;
            end
        end
    end

endmodule

// File: rtl/trap_sequencer.sv
// Arbitrates exceptions, xRET and interrupts, drains the pipeline, strobes
// the commit into csr_regfile and then redirects the front end.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | waiting for a winner; holdoff counts down here
// DRAIN    | flush_req high until flush_ack or drain timeout
// COMMIT   | one-cycle exception_pending strobe with latched cause/pc
// REDIRECT | one-cycle redirect to epc; reload interrupt holdoff
module trap_sequencer
    import trap_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int DRAIN_TIMEOUT = 16,
    parameter int IRQ_HOLDOFF   = 2
) (
    input logic              clk,
    input logic              rst,
    trap_sequencer_if.master bus
);

    localparam int DC_W = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
    localparam int HO_W = (IRQ_HOLDOFF > 1) ? $clog2(IRQ_HOLDOFF + 1) : 1;
    localparam logic [DC_W-1:0] DRAIN_LAST  = DC_W'(DRAIN_TIMEOUT - 1);
    localparam logic [HO_W-1:0] HOLDOFF_VAL = HO_W'(IRQ_HOLDOFF);

    trap_state_t state, state_nxt;

    logic [DC_W-1:0] drain_cnt;
    logic [HO_W-1:0] holdoff_cnt;
    logic [XLEN-1:0] lat_cause;
    logic [XLEN-1:0] lat_pc;
    logic            lat_mret;
    logic            lat_sret;
    logic            timeout_err;

    logic            irq_valid;
    logic [4:0]      irq_code;
    logic            take_exc, take_mret, take_sret, take_irq;
    logic            timeout_hit;

    logic            flush_req_c, pending_c, redirect_c;
    logic [XLEN-1:0] m_cause_c, pc_exc_c;
    logic            m_ret_c, s_ret_c;

    irq_priority_enc u_irq_enc (
        .current_mode (bus.current_mode),
        .m_eie        (bus.m_eie),
        .m_tie        (bus.m_tie),
        .s_eie        (bus.s_eie),
        .s_tie        (bus.s_tie),
        .m_interrupt  (bus.m_interrupt),
        .m_timer      (bus.m_timer),
        .s_interrupt  (bus.s_interrupt),
        .s_timer      (bus.s_timer),
        .irq_block    (holdoff_cnt != '0),
        .irq_valid    (irq_valid),
        .irq_code     (irq_code)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        take_exc    = 1'b0;
        take_mret   = 1'b0;
        take_sret   = 1'b0;
        take_irq    = 1'b0;
        timeout_hit = 1'b0;
        flush_req_c = 1'b0;
        pending_c   = 1'b0;
        redirect_c  = 1'b0;
        m_cause_c   = '0;
        pc_exc_c    = '0;
        m_ret_c     = 1'b0;
        s_ret_c     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.exc_valid) begin
                    take_exc = 1'b1;
                end else if (bus.mret_req) begin
                    take_mret = 1'b1;
                end else if (bus.sret_req) begin
                    take_sret = 1'b1;
                end else if (irq_valid) begin
                    take_irq = 1'b1;
                end
                if (bus.exc_valid || bus.mret_req || bus.sret_req || irq_valid) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                flush_req_c = 1'b1;
                if (bus.flush_ack) begin
                    state_nxt = ST_COMMIT;
                end else if (drain_cnt == DRAIN_LAST) begin
                    state_nxt   = ST_COMMIT;
                    timeout_hit = 1'b1;
                end
            end
            ST_COMMIT: begin
                pending_c = 1'b1;
                m_cause_c = lat_cause;
                pc_exc_c  = lat_pc;
                m_ret_c   = lat_mret;
                s_ret_c   = lat_sret;
                state_nxt = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                redirect_c = 1'b1;
                state_nxt  = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drain_cnt   <= '0;
            holdoff_cnt <= '0;
            lat_cause   <= '0;
            lat_pc      <= '0;
            lat_mret    <= 1'b0;
            lat_sret    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (take_exc) begin
                lat_cause <= {{(XLEN-6){1'b0}}, bus.exc_cause};
                lat_pc    <= bus.exc_pc;
                lat_mret  <= 1'b0;
                lat_sret  <= 1'b0;
            end else if (take_mret || take_sret) begin
                lat_cause <= '0;
                lat_pc    <= '0;
                lat_mret  <= take_mret;
                lat_sret  <= take_sret;
            end else if (take_irq) begin
                lat_cause <= {1'b1, {(XLEN-6){1'b0}}, irq_code};
                lat_pc    <= bus.commit_pc;
                lat_mret  <= 1'b0;
                lat_sret  <= 1'b0;
            end

            if (state == ST_IDLE) begin
                drain_cnt <= '0;
            end else if ((state == ST_DRAIN) && (drain_cnt != DRAIN_LAST)) begin
                drain_cnt <= drain_cnt + 1'b1;
            end

            // holdoff only masks interrupts; it freezes outside IDLE
            if (state == ST_REDIRECT) begin
                holdoff_cnt <= HOLDOFF_VAL;
            end else if ((state == ST_IDLE) && (holdoff_cnt != '0)) begin
                holdoff_cnt <= holdoff_cnt - 1'b1;
            end

            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end
        end
    end

    assign bus.flush_req         = flush_req_c;
    assign bus.exception_pending = pending_c;
    assign bus.m_cause           = m_cause_c;
    assign bus.pc_exc            = pc_exc_c;
    assign bus.m_ret             = m_ret_c;
    assign bus.s_ret             = s_ret_c;
    assign bus.redirect          = redirect_c;
    assign bus.busy              = (state != ST_IDLE);
    assign bus.drain_timeout_err = timeout_err;

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: directed scenarios plus randomized
// requests checked against a rule-level reference model.
module tb_trap_sequencer;

    localparam int XLEN          = 32;
    localparam int DRAIN_TIMEOUT = 16;
    localparam int IRQ_HOLDOFF   = 2;

    typedef struct {
        bit        valid;
        bit [31:0] cause;
        bit [31:0] pc;
        bit        mret;
        bit        sret;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    trap_sequencer_if #(.XLEN(XLEN)) bus ();

    trap_sequencer #(
        .XLEN          (XLEN),
        .DRAIN_TIMEOUT (DRAIN_TIMEOUT),
        .IRQ_HOLDOFF   (IRQ_HOLDOFF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic clear_inputs();
        bus.exc_valid    = 1'b0;
        bus.exc_cause    = '0;
        bus.exc_pc       = '0;
        bus.mret_req     = 1'b0;
        bus.sret_req     = 1'b0;
        bus.commit_pc    = '0;
        bus.current_mode = 2'b11;
        bus.m_eie        = 1'b0;
        bus.m_tie        = 1'b0;
        bus.s_eie        = 1'b0;
        bus.s_tie        = 1'b0;
        bus.m_interrupt  = 1'b0;
        bus.m_timer      = 1'b0;
        bus.s_interrupt  = 1'b0;
        bus.s_timer      = 1'b0;
        bus.flush_ack    = 1'b0;
    endtask

    // Reference: which request wins and what csr_regfile should receive
    function automatic exp_t model(input bit ev, input bit [5:0] ec, input bit [31:0] epc,
                                   input bit mr, input bit sr, input bit [31:0] cpc,
                                   input bit [1:0] mode, input bit meie, input bit mtie,
                                   input bit seie, input bit stie, input bit mi, input bit mt,
                                   input bit si, input bit st, input bit blocked);
        exp_t e;
        bit mei, mti, sei, sti;
        e = '{valid: 1'b0, cause: 32'd0, pc: 32'd0, mret: 1'b0, sret: 1'b0};
        mei = mi && (mode != 2'b11 || meie);
        mti = mt && (mode != 2'b11 || mtie);
        sei = si && (mode == 2'b00 || (mode == 2'b01 && seie));
        sti = st && (mode == 2'b00 || (mode == 2'b01 && stie));
        if (ev) begin
            e.valid = 1'b1;
            e.cause = 32'(ec);
            e.pc    = epc;
        end else if (mr) begin
            e.valid = 1'b1;
            e.mret  = 1'b1;
        end else if (sr) begin
            e.valid = 1'b1;
            e.sret  = 1'b1;
        end else if (!blocked && (mei || mti || sei || sti)) begin
            e.valid = 1'b1;
            e.pc    = cpc;
            if (mei)      e.cause = 32'h8000_0000 + 32'd11;
            else if (mti) e.cause = 32'h8000_0000 + 32'd7;
            else if (sei) e.cause = 32'h8000_0000 + 32'd9;
            else          e.cause = 32'h8000_0000 + 32'd5;
        end
        return e;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        n_checks++;
        if ({bus.flush_req, bus.exception_pending, bus.m_ret, bus.s_ret, bus.redirect,
             bus.busy, bus.drain_timeout_err} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 0000000", {bus.flush_req,
                     bus.exception_pending, bus.m_ret, bus.s_ret, bus.redirect, bus.busy,
                     bus.drain_timeout_err});
        end
        n_checks++;
        if (bus.m_cause !== 32'd0 || bus.pc_exc !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_cause_pc: got %h/%h expected 0/0", bus.m_cause, bus.pc_exc);
        end
    endtask

    task automatic test_exception();
        bus.flush_ack = 1'b1;
        bus.exc_valid = 1'b1;
        bus.exc_cause = 6'd2;
        bus.exc_pc    = 32'h100;
        step();
        bus.exc_valid = 1'b0;
        n_checks++;
        if ({bus.flush_req, bus.exception_pending} !== 2'b10) begin
            n_fail++;
            $display("FAIL exc_n1_flush: got %b expected 10", {bus.flush_req, bus.exception_pending});
        end
        step();
        n_checks++;
        if (bus.exception_pending !== 1'b1 || bus.m_cause !== 32'h2 || bus.pc_exc !== 32'h100) begin
            n_fail++;
            $display("FAIL exc_n2_commit: got pend=%b cause=%h pc=%h expected 1/00000002/00000100",
                     bus.exception_pending, bus.m_cause, bus.pc_exc);
        end
        n_checks++;
        if ({bus.m_ret, bus.s_ret, bus.flush_req} !== 3'b000) begin
            n_fail++;
            $display("FAIL exc_n2_flags: got %b expected 000", {bus.m_ret, bus.s_ret, bus.flush_req});
        end
        step();
        n_checks++;
        if (bus.redirect !== 1'b1 || bus.exception_pending !== 1'b0 || bus.m_cause !== 32'd0) begin
            n_fail++;
            $display("FAIL exc_n3_redirect: got red=%b pend=%b cause=%h expected 1/0/0",
                     bus.redirect, bus.exception_pending, bus.m_cause);
        end
        step();
        n_checks++;
        if (bus.busy !== 1'b0 || bus.redirect !== 1'b0) begin
            n_fail++;
            $display("FAIL exc_n4_idle: got busy=%b red=%b expected 0/0", bus.busy, bus.redirect);
        end
        clear_inputs();
    endtask

    task automatic test_irq_mode_u();
        logic [31:0] cpc;
        idle(IRQ_HOLDOFF + 1);
        cpc = $urandom;
        bus.flush_ack    = 1'b1;
        bus.current_mode = 2'b00;
        bus.m_timer      = 1'b1;
        bus.s_interrupt  = 1'b1;
        bus.commit_pc    = cpc;
        step();
        clear_inputs();
        bus.flush_ack = 1'b1;
        step();
        n_checks++;
        if (bus.exception_pending !== 1'b1 || bus.m_cause !== 32'h8000_0007 || bus.pc_exc !== cpc) begin
            n_fail++;
            $display("FAIL irq_mti_u: got pend=%b cause=%h pc=%h expected 1/80000007/%h",
                     bus.exception_pending, bus.m_cause, bus.pc_exc, cpc);
        end
        step();
        n_checks++;
        if (bus.redirect !== 1'b1) begin
            n_fail++;
            $display("FAIL irq_redirect: got %b expected 1", bus.redirect);
        end
        clear_inputs();
    endtask

    task automatic test_priority();
        logic [5:0]  ec;
        logic [31:0] epc;
        idle(IRQ_HOLDOFF + 1);
        ec  = 6'($urandom_range(0, 15));
        epc = $urandom;
        bus.flush_ack    = 1'b1;
        bus.current_mode = 2'b11;
        bus.m_eie        = 1'b1;
        bus.m_interrupt  = 1'b1;
        bus.mret_req     = 1'b1;
        bus.exc_valid    = 1'b1;
        bus.exc_cause    = ec;
        bus.exc_pc       = epc;
        step();
        clear_inputs();
        bus.flush_ack = 1'b1;
        step();
        n_checks++;
        if (bus.exception_pending !== 1'b1 || bus.m_cause !== 32'(ec) || bus.pc_exc !== epc
            || bus.m_ret !== 1'b0) begin
            n_fail++;
            $display("FAIL priority_exc: got pend=%b cause=%h pc=%h mret=%b expected 1/%h/%h/0",
                     bus.exception_pending, bus.m_cause, bus.pc_exc, bus.m_ret, 32'(ec), epc);
        end
        step();
        step();
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL priority_single: got busy=%b expected 0", bus.busy);
        end
        clear_inputs();
    endtask

    task automatic test_holdoff();
        int n;
        idle(IRQ_HOLDOFF + 1);
        bus.flush_ack    = 1'b1;
        bus.current_mode = 2'b00;
        bus.m_interrupt  = 1'b1;
        n = 0;
        while (bus.redirect !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        n_checks++;
        if (bus.redirect !== 1'b1) begin
            n_fail++;
            $display("FAIL holdoff_first_redirect: got timeout expected redirect");
        end
        n = 0;
        do begin
            step();
            n++;
        end while (bus.flush_req !== 1'b1 && n < 20);
        n_checks++;
        if (n != IRQ_HOLDOFF + 2) begin
            n_fail++;
            $display("FAIL holdoff_gap: got flush_req %0d cycles after redirect expected %0d",
                     n, IRQ_HOLDOFF + 2);
        end
        bus.m_interrupt = 1'b0;
        step();
        n_checks++;
        if (bus.exception_pending !== 1'b1 || bus.m_cause !== 32'h8000_000B) begin
            n_fail++;
            $display("FAIL holdoff_mei: got pend=%b cause=%h expected 1/8000000b",
                     bus.exception_pending, bus.m_cause);
        end
        step();
        clear_inputs();
    endtask

    task automatic test_random();
        int   pos;
        exp_t e;
        bit   ev, mr, sr, meie, mtie, seie, stie, mi, mt, si, st;
        bit [5:0]  ec;
        bit [31:0] epc, cpc;
        bit [1:0]  mode;
        int   d, j, g;
        idle(IRQ_HOLDOFF + 2);
        pos = 100;
        for (int it = 0; it < 80; it++) begin
            g = $urandom_range(1, 3);
            idle(g);
            pos += g;
            ev   = ($urandom_range(0, 4) == 0);
            mr   = ($urandom_range(0, 5) == 0);
            sr   = ($urandom_range(0, 5) == 0);
            ec   = 6'($urandom);
            epc  = $urandom;
            cpc  = $urandom;
            case ($urandom_range(0, 2))
                0:       mode = 2'b00;
                1:       mode = 2'b01;
                default: mode = 2'b11;
            endcase
            meie = 1'($urandom); mtie = 1'($urandom); seie = 1'($urandom); stie = 1'($urandom);
            mi   = 1'($urandom); mt   = 1'($urandom); si   = 1'($urandom); st   = 1'($urandom);
            e = model(ev, ec, epc, mr, sr, cpc, mode, meie, mtie, seie, stie, mi, mt, si, st,
                      pos <= IRQ_HOLDOFF);
            d = $urandom_range(0, 3);
            bus.exc_valid = ev;  bus.exc_cause = ec;  bus.exc_pc = epc;
            bus.mret_req  = mr;  bus.sret_req  = sr;  bus.commit_pc = cpc;
            bus.current_mode = mode;
            bus.m_eie = meie; bus.m_tie = mtie; bus.s_eie = seie; bus.s_tie = stie;
            bus.m_interrupt = mi; bus.m_timer = mt; bus.s_interrupt = si; bus.s_timer = st;
            bus.flush_ack = 1'b0;
            step();
            pos++;
            clear_inputs();
            if (e.valid) begin
                j = 0;
                while (bus.exception_pending !== 1'b1 && j < 40) begin
                    bus.flush_ack = (j >= d);
                    step();
                    j++;
                end
                bus.flush_ack = 1'b0;
                n_checks++;
                if (j != d + 1) begin
                    n_fail++;
                    $display("FAIL rand_drain_len it=%0d: got %0d expected %0d", it, j, d + 1);
                end
                n_checks++;
                if (bus.exception_pending !== 1'b1 || bus.m_cause !== e.cause || bus.pc_exc !== e.pc
                    || bus.m_ret !== e.mret || bus.s_ret !== e.sret) begin
                    n_fail++;
                    $display("FAIL rand_commit it=%0d: got pend=%b cause=%h pc=%h ret=%b%b expected 1/%h/%h/%b%b",
                             it, bus.exception_pending, bus.m_cause, bus.pc_exc, bus.m_ret, bus.s_ret,
                             e.cause, e.pc, e.mret, e.sret);
                end
                step();
                n_checks++;
                if (bus.redirect !== 1'b1 || bus.m_cause !== 32'd0 || bus.s_ret !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rand_redirect it=%0d: got red=%b cause=%h sret=%b expected 1/0/0",
                             it, bus.redirect, bus.m_cause, bus.s_ret);
                end
                pos = 0;
            end else begin
                n_checks++;
                if (bus.busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rand_no_accept it=%0d: got busy=%b expected 0", it, bus.busy);
                end
            end
        end
        clear_inputs();
    endtask

    task automatic test_timeout();
        int cnt;
        idle(IRQ_HOLDOFF + 1);
        bus.flush_ack = 1'b0;
        bus.exc_valid = 1'b1;
        bus.exc_cause = 6'd13;
        bus.exc_pc    = 32'h2000;
        step();
        bus.exc_valid = 1'b0;
        cnt = 0;
        while (bus.flush_req === 1'b1 && cnt < 40) begin
            step();
            cnt++;
        end
        n_checks++;
        if (cnt != DRAIN_TIMEOUT) begin
            n_fail++;
            $display("FAIL timeout_flush_len: got %0d expected %0d", cnt, DRAIN_TIMEOUT);
        end
        n_checks++;
        if (bus.exception_pending !== 1'b1 || bus.m_cause !== 32'd13 || bus.drain_timeout_err !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_commit: got pend=%b cause=%h err=%b expected 1/0000000d/1",
                     bus.exception_pending, bus.m_cause, bus.drain_timeout_err);
        end
        idle(6);
        n_checks++;
        if (bus.drain_timeout_err !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_sticky: got %b expected 1", bus.drain_timeout_err);
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        bit saw_pend;
        idle(IRQ_HOLDOFF + 1);
        bus.flush_ack = 1'b0;
        bus.mret_req  = 1'b1;
        step();
        bus.mret_req = 1'b0;
        n_checks++;
        if (bus.flush_req !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_drain: got flush_req=%b expected 1", bus.flush_req);
        end
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if ({bus.flush_req, bus.exception_pending, bus.m_ret, bus.s_ret, bus.redirect, bus.busy,
             bus.drain_timeout_err} !== 7'b0 || bus.m_cause !== 32'd0 || bus.pc_exc !== 32'd0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got flags=%b cause=%h pc=%h expected 0/0/0",
                     {bus.flush_req, bus.exception_pending, bus.m_ret, bus.s_ret, bus.redirect,
                      bus.busy, bus.drain_timeout_err}, bus.m_cause, bus.pc_exc);
        end
        saw_pend = 1'b0;
        repeat (6) begin
            step();
            if (bus.exception_pending === 1'b1) saw_pend = 1'b1;
        end
        n_checks++;
        if (saw_pend !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_no_strobe: got strobe=%b expected 0", saw_pend);
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_exception();
        test_irq_mode_u();
        test_priority();
        test_holdoff();
        test_random();
        test_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
